// File: rtl/fifo_pair_pkg.sv
// Shared constants for the fifo_pair slice: default geometry, data widths and
// the pointer/occupancy widths derived from the default depth.
package fifo_pair_pkg;

  localparam int DEPTH_DEFAULT    = 4;
  localparam int AF_LEVEL_DEFAULT = 3;

  localparam int FIFO1_W = 32;
  localparam int FIFO2_W = 8;

  localparam int PTR_W = $clog2(DEPTH_DEFAULT);
  localparam int OCC_W = PTR_W + 1;

  function automatic int ptr_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a registered one-cycle read port and occupancy-decoded
// full/empty/almost-full flags; a write to a full FIFO is accepted only alongside a pop.
module fifo_sync
  import fifo_pair_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int AF_LEVEL = AF_LEVEL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst1_n_sync,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             wr_drop
);

  localparam int PTR_BITS = ptr_bits(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] AF_CNT   = CNT_BITS'(AF_LEVEL);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q;
  logic [PTR_BITS-1:0] rd_ptr_q;
  logic [CNT_BITS-1:0] count_q;
  logic                pop_acc;
  logic                wr_acc;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign afull   = (count_q >= AF_CNT);

  // A pop frees the slot the same cycle, so a full FIFO can still take a write.
  assign pop_acc = rd_en && !empty;
  assign wr_acc  = wr_en && (!full || pop_acc);
  assign wr_drop = wr_en && !wr_acc;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst1_n_sync) begin
    if (!rst1_n_sync) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_acc;
      if (pop_acc) begin
        rd_data  <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
      end
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
      case ({wr_acc, pop_acc})
        2'b10:   count_q <= count_q + CNT_BITS'(1);
        2'b01:   count_q <= count_q - CNT_BITS'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_pair.sv
// Two FIFOs written by one strobe (32-bit and 8-bit), popped independently.
// Define FIFO_PAIR_OVF_ERR_EN to build the sticky ovf_err flag; otherwise it is tied low.
module fifo_pair
  import fifo_pair_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int AF_LEVEL = AF_LEVEL_DEFAULT
) (
  input  logic               clk,
  input  logic               rst1_n_sync,
  input  logic               write_en,
  input  logic [FIFO1_W-1:0] data_fifo1,
  input  logic [FIFO2_W-1:0] data_fifo2,
  output logic               fifo1_full,
  output logic               fifo2_full,
  output logic               fifo1_afull,
  input  logic               rd1_en,
  output logic [FIFO1_W-1:0] rd1_data,
  output logic               rd1_valid,
  output logic               fifo1_empty,
  input  logic               rd2_en,
  output logic [FIFO2_W-1:0] rd2_data,
  output logic               rd2_valid,
  output logic               fifo2_empty,
  output logic               ovf_err
);

  logic drop1;
  logic drop2;
  logic fifo2_afull_unused;

  fifo_sync #(.WIDTH(FIFO1_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_fifo1 (
    .clk         (clk),
    .rst1_n_sync (rst1_n_sync),
    .wr_en       (write_en),
    .wr_data     (data_fifo1),
    .rd_en       (rd1_en),
    .rd_data     (rd1_data),
    .rd_valid    (rd1_valid),
    .full        (fifo1_full),
    .empty       (fifo1_empty),
    .afull       (fifo1_afull),
    .wr_drop     (drop1)
  );

  fifo_sync #(.WIDTH(FIFO2_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_fifo2 (
    .clk         (clk),
    .rst1_n_sync (rst1_n_sync),
    .wr_en       (write_en),
    .wr_data     (data_fifo2),
    .rd_en       (rd2_en),
    .rd_data     (rd2_data),
    .rd_valid    (rd2_valid),
    .full        (fifo2_full),
    .empty       (fifo2_empty),
    .afull       (fifo2_afull_unused),
    .wr_drop     (drop2)
  );

`ifdef FIFO_PAIR_OVF_ERR_EN
  always_ff @(posedge clk or negedge rst1_n_sync) begin
    if (!rst1_n_sync) ovf_err <= 1'b0;
    else if (drop1 || drop2) ovf_err <= 1'b1;
  end
`else
  logic drop_unused;
  assign drop_unused = drop1 | drop2;
  assign ovf_err     = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_pair.sv
// Bench for fifo_pair: directed scenarios plus randomized traffic, checked against
// a queue-based model of the two FIFOs.
module tb_fifo_pair;

  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic        clk = 1'b0;
  logic        rst1_n_sync = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] data_fifo1 = '0;
  logic [7:0]  data_fifo2 = '0;
  logic        rd1_en = 1'b0;
  logic        rd2_en = 1'b0;
  logic        fifo1_full, fifo2_full, fifo1_afull;
  logic [31:0] rd1_data;
  logic        rd1_valid, fifo1_empty;
  logic [7:0]  rd2_data;
  logic        rd2_valid, fifo2_empty;
  logic        ovf_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] q1 [$];
  logic [7:0]  q2 [$];
  logic [31:0] exp_rd1;
  logic [7:0]  exp_rd2;
  logic        exp_v1, exp_v2, ovf_m;

  always #5 clk = ~clk;

  fifo_pair #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk         (clk),
    .rst1_n_sync (rst1_n_sync),
    .write_en    (write_en),
    .data_fifo1  (data_fifo1),
    .data_fifo2  (data_fifo2),
    .fifo1_full  (fifo1_full),
    .fifo2_full  (fifo2_full),
    .fifo1_afull (fifo1_afull),
    .rd1_en      (rd1_en),
    .rd1_data    (rd1_data),
    .rd1_valid   (rd1_valid),
    .fifo1_empty (fifo1_empty),
    .rd2_en      (rd2_en),
    .rd2_data    (rd2_data),
    .rd2_valid   (rd2_valid),
    .fifo2_empty (fifo2_empty),
    .ovf_err     (ovf_err)
  );

  function automatic logic exp_ovf();
`ifdef FIFO_PAIR_OVF_ERR_EN
    return ovf_m;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    q1.delete();
    q2.delete();
    exp_rd1 = '0;
    exp_rd2 = '0;
    exp_v1  = 1'b0;
    exp_v2  = 1'b0;
    ovf_m   = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic step(input logic we, input logic [31:0] d1, input logic [7:0] d2,
                      input logic r1, input logic r2);
    bit p1, p2;
    @(negedge clk);
    write_en = we; data_fifo1 = d1; data_fifo2 = d2; rd1_en = r1; rd2_en = r2;
    p1 = r1 && (q1.size() > 0);
    p2 = r2 && (q2.size() > 0);
    exp_v1 = p1;
    exp_v2 = p2;
    if (p1) exp_rd1 = q1.pop_front();
    if (p2) exp_rd2 = q2.pop_front();
    if (we) begin
      if (q1.size() < DEPTH) q1.push_back(d1); else ovf_m = 1'b1;
      if (q2.size() < DEPTH) q2.push_back(d2); else ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    write_en = 1'b0; rd1_en = 1'b0; rd2_en = 1'b0;
    rst1_n_sync = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst1_n_sync = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (fifo1_empty !== 1'b1 || fifo2_empty !== 1'b1) begin bad++;
      $display("FAIL reset_empty got=%b%b exp=11", fifo1_empty, fifo2_empty); end
    total++; if (fifo1_full !== 1'b0 || fifo2_full !== 1'b0 || fifo1_afull !== 1'b0) begin bad++;
      $display("FAIL reset_full got=%b%b%b exp=000", fifo1_full, fifo2_full, fifo1_afull); end
    total++; if (rd1_valid !== 1'b0 || rd2_valid !== 1'b0 || rd1_data !== 32'h0 || rd2_data !== 8'h0) begin bad++;
      $display("FAIL reset_rd got=%b%b %h %h exp=00 0 0", rd1_valid, rd2_valid, rd1_data, rd2_data); end
    total++; if (ovf_err !== 1'b0) begin bad++;
      $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
  endtask

  task automatic test_order();
    do_reset();
    step(1'b1, 32'h11223344, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 32'h55667788, 8'hB2, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    total++; if (rd1_valid !== 1'b1 || rd1_data !== 32'h11223344) begin bad++;
      $display("FAIL order_rd1_first got=%b/%h exp=1/11223344", rd1_valid, rd1_data); end
    total++; if (rd2_valid !== 1'b1 || rd2_data !== 8'hA1) begin bad++;
      $display("FAIL order_rd2_first got=%b/%h exp=1/a1", rd2_valid, rd2_data); end
    step(1'b0, '0, '0, 1'b1, 1'b1);
    total++; if (rd1_valid !== 1'b1 || rd1_data !== 32'h55667788) begin bad++;
      $display("FAIL order_rd1_second got=%b/%h exp=1/55667788", rd1_valid, rd1_data); end
    total++; if (rd2_valid !== 1'b1 || rd2_data !== 8'hB2) begin bad++;
      $display("FAIL order_rd2_second got=%b/%h exp=1/b2", rd2_valid, rd2_data); end
    idle();
    total++; if (rd1_valid !== 1'b0 || rd1_data !== 32'h55667788 || fifo1_empty !== 1'b1) begin bad++;
      $display("FAIL order_end got=v%b d%h e%b exp=v0 d55667788 e1", rd1_valid, rd1_data, fifo1_empty); end
  endtask

  task automatic test_fill_and_full_pop();
    logic [31:0] v [DEPTH];
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      v[i] = $urandom;
      step(1'b1, v[i], 8'(i), 1'b0, 1'b0);
      total++; if (fifo1_afull !== (i + 1 >= AF) || fifo1_full !== (i + 1 == DEPTH)) begin bad++;
        $display("FAIL fill_flags n=%0d got af=%b f=%b exp af=%b f=%b", i + 1,
                 fifo1_afull, fifo1_full, (i + 1 >= AF), (i + 1 == DEPTH)); end
    end
    step(1'b1, 32'hBAD0BAD0, 8'hEE, 1'b0, 1'b0);
    total++; if (ovf_err !== exp_ovf() || fifo1_full !== 1'b1) begin bad++;
      $display("FAIL fill_drop got ovf=%b full=%b exp ovf=%b full=1", ovf_err, fifo1_full, exp_ovf()); end
    // Full FIFO1 with a same-cycle pop must take the write.
    step(1'b1, 32'hDEADBEEF, 8'h00, 1'b1, 1'b0);
    total++; if (rd1_valid !== 1'b1 || rd1_data !== v[0] || fifo1_full !== 1'b1) begin bad++;
      $display("FAIL full_pop got v=%b d=%h full=%b exp v=1 d=%h full=1", rd1_valid, rd1_data, fifo1_full, v[0]); end
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      total++; if (rd1_data !== ((i < DEPTH) ? v[i] : 32'hDEADBEEF)) begin bad++;
        $display("FAIL full_pop_drain i=%0d got=%h exp=%h", i, rd1_data, (i < DEPTH) ? v[i] : 32'hDEADBEEF); end
    end
    total++; if (fifo1_empty !== 1'b1) begin bad++;
      $display("FAIL full_pop_empty got=%b exp=1", fifo1_empty); end
  endtask

  task automatic test_empty_pop();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      total++; if (rd2_valid !== 1'b0 || rd2_data !== 8'h00 || fifo2_empty !== 1'b1) begin bad++;
        $display("FAIL empty_pop i=%0d got v=%b d=%h e=%b exp v=0 d=00 e=1", i, rd2_valid, rd2_data, fifo2_empty); end
    end
    step(1'b1, 32'h0, 8'hC3, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    total++; if (rd2_valid !== 1'b1 || rd2_data !== 8'hC3 || fifo2_empty !== 1'b1) begin bad++;
      $display("FAIL empty_pop_after got v=%b d=%h e=%b exp v=1 d=c3 e=1", rd2_valid, rd2_data, fifo2_empty); end
    // Write while empty with a pop request: pop ignored, write stored.
    step(1'b1, 32'h0, 8'h3C, 1'b0, 1'b1);
    total++; if (rd2_valid !== 1'b0 || fifo2_empty !== 1'b0) begin bad++;
      $display("FAIL empty_wr_pop got v=%b e=%b exp v=0 e=0", rd2_valid, fifo2_empty); end
    idle();
  endtask

  task automatic test_asym_drain();
    logic [7:0] b [DEPTH];
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      b[i] = 8'($urandom);
      step(1'b1, $urandom, b[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h0000CAFE, 8'h5A, 1'b0, 1'b0);
    total++; if (fifo1_empty !== 1'b0 || fifo2_full !== 1'b1 || ovf_err !== exp_ovf()) begin bad++;
      $display("FAIL asym got e1=%b f2=%b ovf=%b exp e1=0 f2=1 ovf=%b", fifo1_empty, fifo2_full, ovf_err, exp_ovf()); end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    total++; if (rd1_data !== 32'h0000CAFE) begin bad++;
      $display("FAIL asym_rd1 got=%h exp=0000cafe", rd1_data); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      total++; if (rd2_data !== b[i]) begin bad++;
        $display("FAIL asym_rd2 i=%0d got=%h exp=%h", i, rd2_data, b[i]); end
    end
    total++; if (fifo2_empty !== 1'b1) begin bad++;
      $display("FAIL asym_rd2_empty got=%b exp=1", fifo2_empty); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, $urandom, 8'($urandom), 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    // Two entries remain, valids high; assert reset away from any edge.
    @(negedge clk);
    #2;
    rst1_n_sync = 1'b0;
    write_en = 1'b0; rd1_en = 1'b0; rd2_en = 1'b0;
    model_clear();
    #1;
    total++; if (fifo1_empty !== 1'b1 || fifo2_empty !== 1'b1 || rd1_valid !== 1'b0 ||
                 rd2_valid !== 1'b0 || ovf_err !== 1'b0) begin bad++;
      $display("FAIL mid_reset got e=%b%b v=%b%b ovf=%b exp e=11 v=00 ovf=0",
               fifo1_empty, fifo2_empty, rd1_valid, rd2_valid, ovf_err); end
    @(negedge clk);
    rst1_n_sync = 1'b1;
    step(1'b1, $urandom, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 8'($urandom), 1'b1, 1'b1);
      total++; if (rd1_valid !== 1'b1 || rd1_data !== exp_rd1 || rd2_data !== exp_rd2) begin bad++;
        $display("FAIL wrap i=%0d got %b/%h/%h exp 1/%h/%h", i, rd1_valid, rd1_data, rd2_data, exp_rd1, exp_rd2); end
    end
  endtask

  task automatic test_random();
    int wp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      wp = ((i / 50) % 2 == 0) ? 75 : 25;
      step($urandom_range(99) < wp, $urandom, 8'($urandom),
           $urandom_range(99) < 50, $urandom_range(99) < 50);
      total++; if (rd1_valid !== exp_v1 || rd1_data !== exp_rd1) begin bad++;
        $display("FAIL rand_rd1 i=%0d got %b/%h exp %b/%h", i, rd1_valid, rd1_data, exp_v1, exp_rd1); end
      total++; if (rd2_valid !== exp_v2 || rd2_data !== exp_rd2) begin bad++;
        $display("FAIL rand_rd2 i=%0d got %b/%h exp %b/%h", i, rd2_valid, rd2_data, exp_v2, exp_rd2); end
      total++; if (fifo1_full !== (q1.size() == DEPTH) || fifo1_empty !== (q1.size() == 0) ||
                   fifo1_afull !== (q1.size() >= AF)) begin bad++;
        $display("FAIL rand_flags1 i=%0d got f=%b e=%b af=%b occ=%0d", i, fifo1_full, fifo1_empty, fifo1_afull, q1.size()); end
      total++; if (fifo2_full !== (q2.size() == DEPTH) || fifo2_empty !== (q2.size() == 0)) begin bad++;
        $display("FAIL rand_flags2 i=%0d got f=%b e=%b occ=%0d", i, fifo2_full, fifo2_empty, q2.size()); end
      total++; if (ovf_err !== exp_ovf()) begin bad++;
        $display("FAIL rand_ovf i=%0d got=%b exp=%b", i, ovf_err, exp_ovf()); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_order();
    test_fill_and_full_pop();
    test_empty_pop();
    test_asym_drain();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
